calc_seq_unit: RTL and testbench

//  Parametrised sequential successor to the combinational +,-,* calculator. Accepts operands x, y and an

---
 rtl/calc_seq_unit.sv | 150 +++++++++++++++
 tb/tb_calc_seq_unit.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/calc_seq_unit.sv
// Sequential +,-,* calculator with a valid/ready handshake on both sides.
// Add/subtract finish in one cycle; multiply is a WIDTH-cycle shift-add.
module calc_seq_unit #(
  parameter int               WIDTH   = 16,
  parameter logic [WIDTH-1:0] ERR_VAL = {WIDTH{1'b1}}
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic [7:0]       op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out,
  output logic             err
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  localparam logic [7:0] OP_ADD = 8'h2B;
  localparam logic [7:0] OP_SUB = 8'h2D;
  localparam logic [7:0] OP_MUL = 8'h2A;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] out_q, out_d;
  logic             err_q, err_d;
  logic             valid_q, valid_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0] mplier_q, mplier_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] acc_sum_s;

  assign in_ready  = (state_q == S_IDLE);
  assign out_valid = valid_q;
  assign out       = out_q;
  assign err       = err_q;

  // State register and datapath registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      out_q    <= {WIDTH{1'b0}};
      err_q    <= 1'b0;
      valid_q  <= 1'b0;
      acc_q    <= {WIDTH{1'b0}};
      mcand_q  <= {WIDTH{1'b0}};
      mplier_q <= {WIDTH{1'b0}};
      cnt_q    <= {CW{1'b0}};
    end else begin
      state_q  <= state_d;
      out_q    <= out_d;
      err_q    <= err_d;
      valid_q  <= valid_d;
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      cnt_q    <= cnt_d;
    end
  end

  // Next-state and datapath update; modulo-2^WIDTH product needs no sign fix-up
  always_comb begin
    state_d   = state_q;
    out_d     = out_q;
    err_d     = err_q;
    valid_d   = valid_q;
    acc_d     = acc_q;
    mcand_d   = mcand_q;
    mplier_d  = mplier_q;
    cnt_d     = cnt_q;
    acc_sum_s = acc_q + (mplier_q[0] ? mcand_q : {WIDTH{1'b0}});

    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          case (op)
            OP_ADD: begin
              out_d   = x + y;
              err_d   = 1'b0;
              valid_d = 1'b1;
              state_d = S_DONE;
            end
            OP_SUB: begin
              out_d   = x - y;
              err_d   = 1'b0;
              valid_d = 1'b1;
              state_d = S_DONE;
            end
            OP_MUL: begin
              acc_d    = {WIDTH{1'b0}};
              mcand_d  = x;
              mplier_d = y;
              cnt_d    = {CW{1'b0}};
              err_d    = 1'b0;
              state_d  = S_MUL;
            end
            default: begin
              out_d   = ERR_VAL;
              err_d   = 1'b1;
              valid_d = 1'b1;
              state_d = S_DONE;
            end
          endcase
        end else begin
          state_d = S_IDLE;
        end
      end

      S_MUL: begin
        acc_d    = acc_sum_s;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + CW'(1);
        if (cnt_q == CNT_LAST) begin
          out_d   = acc_sum_s;
          valid_d = 1'b1;
          state_d = S_DONE;
        end else begin
          state_d = S_MUL;
        end
      end

      S_DONE: begin
        if (out_ready) begin
          valid_d = 1'b0;
          state_d = S_IDLE;
        end else begin
          valid_d = 1'b1;
          state_d = S_DONE;
        end
      end

      default: begin
        valid_d = 1'b0;
        state_d = S_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_calc_seq_unit.sv
// Randomized self-checking bench for calc_seq_unit against a plain-arithmetic reference.
module tb_calc_seq_unit;

  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] x;
  logic [W-1:0] y;
  logic [7:0]   op;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out;
  logic         err;

  int checks = 0;
  int errors = 0;

  calc_seq_unit #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .x         (x),
    .y         (y),
    .op        (op),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out       (out),
    .err       (err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference: result word, error flag and latency straight from the opcode rules.
  task automatic model(input logic [W-1:0] a, input logic [W-1:0] b, input logic [7:0] o,
                       output logic [W-1:0] res, output logic e, output int lat);
    logic [2*W-1:0] prod;
    e   = 1'b0;
    lat = 1;
    case (o)
      8'h2B: res = a + b;
      8'h2D: res = a - b;
      8'h2A: begin
        prod = a * b;
        res  = prod[W-1:0];
        lat  = W + 1;
      end
      default: begin
        res = {W{1'b1}};
        e   = 1'b1;
      end
    endcase
  endtask

  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic [7:0] o,
                        input int hold);
    logic [W-1:0] eo;
    logic         ee;
    int           elat;
    int           lat;
    int           n;
    model(a, b, o, eo, ee, elat);
    n = 0;
    while (!in_ready && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    check("ready_wait", {31'd0, in_ready}, 32'd1);
    x = a; y = b; op = o; in_valid = 1'b1;
    out_ready = (hold == 0);
    @(posedge clk); #1;
    in_valid = 1'b0;
    x = W'($urandom); y = W'($urandom); op = 8'($urandom);
    lat = 1;
    while (!out_valid && lat < 100) begin
      check("busy_ready", {31'd0, in_ready}, 32'd0);
      @(posedge clk); #1;
      lat++;
    end
    check("latency", lat, elat);
    check("out", {16'd0, out}, {16'd0, eo});
    check("err", {31'd0, err}, {31'd0, ee});
    check("done_ready", {31'd0, in_ready}, 32'd0);
    for (int i = 0; i < hold; i++) begin
      x = W'($urandom); y = W'($urandom); op = 8'($urandom);
      in_valid = 1'($urandom);
      @(posedge clk); #1;
      check("hold_valid", {31'd0, out_valid}, 32'd1);
      check("hold_out", {16'd0, out}, {16'd0, eo});
      check("hold_err", {31'd0, err}, {31'd0, ee});
      check("hold_ready", {31'd0, in_ready}, 32'd0);
    end
    out_ready = 1'b1;
    in_valid  = 1'b1;
    op        = 8'h2B;
    @(posedge clk); #1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    check("consumed", {31'd0, out_valid}, 32'd0);
    check("idle_ready", {31'd0, in_ready}, 32'd1);
  endtask

  initial begin
    logic [7:0] ro;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    x = '0; y = '0; op = 8'h00;
    #12;
    check("rst_valid", {31'd0, out_valid}, 32'd0);
    check("rst_out", {16'd0, out}, 32'd0);
    check("rst_err", {31'd0, err}, 32'd0);
    check("rst_ready", {31'd0, in_ready}, 32'd1);
    @(negedge clk); rst = 1'b0;

    run_op(16'd3, 16'd4, 8'h2B, 0);
    run_op(16'd5, 16'd7, 8'h2D, 0);
    run_op(16'h8000, 16'd1, 8'h2D, 0);
    run_op(16'hFFFD, 16'd7, 8'h2A, 0);
    run_op(16'h0100, 16'h0100, 8'h2A, 0);
    run_op(16'd1, 16'd1, 8'h2F, 0);
    run_op(16'd1, 16'd1, 8'hAB, 0);
    run_op(16'h1234, 16'h4321, 8'h2B, 10);
    run_op(16'h7FFF, 16'h8001, 8'h2A, 10);

    // Reset in the middle of a multiply, while cnt is 5
    @(negedge clk);
    x = 16'd7; y = 16'd9; op = 8'h2A; in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (5) begin
      @(posedge clk); #1;
    end
    rst = 1'b1;
    #1;
    check("mrst_valid", {31'd0, out_valid}, 32'd0);
    check("mrst_out", {16'd0, out}, 32'd0);
    check("mrst_err", {31'd0, err}, 32'd0);
    @(negedge clk); rst = 1'b0;
    repeat (W + 4) begin
      @(posedge clk); #1;
      check("no_stale", {31'd0, out_valid}, 32'd0);
      check("post_rst_ready", {31'd0, in_ready}, 32'd1);
    end
    out_ready = 1'b0;
    run_op(16'd2, 16'd3, 8'h2A, 0);

    for (int k = 0; k < 40; k++) begin
      case ($urandom_range(0, 4))
        0: ro = 8'h2B;
        1: ro = 8'h2D;
        2: ro = 8'h2A;
        3: ro = 8'h2A;
        default: ro = 8'($urandom);
      endcase
      run_op(W'($urandom), W'($urandom), ro, int'($urandom_range(0, 3)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
